// File: rtl/mdu_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op encodings,
// request record and default latencies. Also used by E-stage control and hazard logic.
package mdu_pkg;

  typedef enum logic [3:0] {
    MD_NONE = 4'd0,
    MULT    = 4'd1,
    MULTU   = 4'd2,
    DIV     = 4'd3,
    DIVU    = 4'd4,
    MTHI    = 4'd5,
    MTLO    = 4'd6,
    MADD    = 4'd7,
    MADDU   = 4'd8,
    MSUB    = 4'd9,
    MSUBU   = 4'd10
  } md_op_e;

  typedef struct packed {
    md_op_e      op;
    logic [31:0] a;
    logic [31:0] b;
  } md_req_t;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  // Busy cycles for an op; 0 means the op completes without occupying the unit.
  function automatic int unsigned md_latency(
    input md_op_e      op,
    input int unsigned mult_cycles = MULT_CYCLES_DEF,
    input int unsigned div_cycles  = DIV_CYCLES_DEF
  );
    case (op)
      MULT, MULTU, MADD, MADDU, MSUB, MSUBU: md_latency = mult_cycles;
      DIV, DIVU:                             md_latency = div_cycles;
      default:                               md_latency = 0;
    endcase
  endfunction

endpackage

// File: rtl/mdu_unit.sv
// Multi-cycle MIPS multiply/divide unit holding architectural HI/LO.
// Define MDU_MADD_EN to add MADD/MADDU/MSUB/MSUBU accumulate ops.
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYC + 1);

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e        state;
  logic [CW-1:0] cnt;
  md_req_t       req_q;
  md_op_e        op_in;
  logic          multi_op;
  logic [63:0]   res;

  assign op_in = md_op_e'(op);
  assign busy  = (state == S_BUSY);

  always_comb begin
    multi_op = 1'b0;
    case (op_in)
      MULT, MULTU, DIV, DIVU: multi_op = 1'b1;
`ifdef MDU_MADD_EN
      MADD, MADDU, MSUB, MSUBU: multi_op = 1'b1;
`endif
      default: multi_op = 1'b0;
    endcase
  end

  // Datapath, evaluated on the latched request and consumed on the commit edge.
  logic [63:0] prod_s, prod_u;
  logic [31:0] mag_a, mag_b, mag_q, mag_r, sdiv_q, sdiv_r;
  logic        b_zero;

  assign prod_u = {32'b0, req_q.a} * {32'b0, req_q.b};
  assign prod_s = {{32{req_q.a[31]}}, req_q.a} * {{32{req_q.b[31]}}, req_q.b};
  assign b_zero = (req_q.b == 32'b0);

  assign mag_a  = req_q.a[31] ? -req_q.a : req_q.a;
  assign mag_b  = req_q.b[31] ? -req_q.b : req_q.b;
  assign mag_q  = b_zero ? 32'b0 : mag_a / mag_b;
  assign mag_r  = b_zero ? 32'b0 : mag_a % mag_b;
  // 0x8000_0000 / -1 lands on quotient 0x8000_0000, remainder 0 with no special case.
  assign sdiv_q = (req_q.a[31] ^ req_q.b[31]) ? -mag_q : mag_q;
  assign sdiv_r = req_q.a[31] ? -mag_r : mag_r;

  always_comb begin
    res = {hi, lo};
    case (req_q.op)
      MULT:  res = prod_s;
      MULTU: res = prod_u;
      DIV:   res = b_zero ? {req_q.a, 32'hFFFF_FFFF} : {sdiv_r, sdiv_q};
      DIVU:  res = b_zero ? {req_q.a, 32'hFFFF_FFFF}
                          : {req_q.a % req_q.b, req_q.a / req_q.b};
`ifdef MDU_MADD_EN
      // HI/LO cannot change while busy, so the live registers equal the start-time value.
      MADD:  res = {hi, lo} + prod_s;
      MADDU: res = {hi, lo} + prod_u;
      MSUB:  res = {hi, lo} - prod_s;
      MSUBU: res = {hi, lo} - prod_u;
`endif
      default: res = {hi, lo};
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      req_q <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (multi_op) begin
              req_q <= '{op: op_in, a: a, b: b};
              cnt   <= CW'(md_latency(op_in, MULT_CYCLES, DIV_CYCLES));
              state <= S_BUSY;
            end else if (op_in == MTHI) begin
              hi <= a;
            end else if (op_in == MTLO) begin
              lo <= a;
            end
          end
        end
        S_BUSY: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            {hi, lo} <= res;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed literal cases plus random ops
// compared every cycle against a cycle-stamped behavioural model.
module tb_mdu_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  mdu_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int ref_lat(input logic [3:0] o);
    case (o)
      MULT, MULTU: return 5;
      DIV, DIVU:   return 10;
`ifdef MDU_MADD_EN
      MADD, MADDU, MSUB, MSUBU: return 5;
`endif
      default: return 0;
    endcase
  endfunction

  function automatic logic [63:0] ref_result(input logic [3:0] o, input logic [31:0] x, y,
                                             input logic [63:0] old);
    int sx, sy;
    logic [63:0] ps, pu;
    sx = int'(x);
    sy = int'(y);
    ps = longint'(sx) * longint'(sy);
    pu = {32'b0, x} * {32'b0, y};
    case (o)
      MULT:  return ps;
      MULTU: return pu;
      DIV: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        return {32'(sx % sy), 32'(sx / sy)};
      end
      DIVU: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
      MADD:  return old + ps;
      MADDU: return old + pu;
      MSUB:  return old - ps;
      MSUBU: return old - pu;
      default: return old;
    endcase
  endfunction

  int unsigned cyc = 0;
  int unsigned m_done = 0;
  bit          m_pend = 1'b0;
  logic [63:0] m_res = '0;
  logic [31:0] m_hi = '0, m_lo = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pend = 1'b0;
      m_hi   = '0;
      m_lo   = '0;
    end else begin
      cyc++;
      if (m_pend) begin
        if (cyc == m_done) begin
          {m_hi, m_lo} = m_res;
          m_pend = 1'b0;
        end
      end else if (start) begin
        if (ref_lat(op) != 0) begin
          m_res  = ref_result(op, a, b, {m_hi, m_lo});
          m_done = cyc + ref_lat(op);
          m_pend = 1'b1;
        end else if (op == MTHI) m_hi = a;
        else if (op == MTLO) m_lo = a;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      checks++;
      if (busy !== m_pend || hi !== m_hi || lo !== m_lo) begin
        errors++;
        $display("FAIL model@cyc%0d: got busy=%b hi=%h lo=%h expected busy=%b hi=%h lo=%h",
                 cyc, busy, hi, lo, m_pend, m_hi, m_lo);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int n);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (busy && k < 100) begin
      k++;
      @(negedge clk);
    end
    chk(nm, {31'b0, busy}, 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20)) - 32'd10;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int n;
    reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    #12;
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    @(negedge clk); #1 reset = 1'b1;

    run_op(MULT, 32'hFFFF_FFFE, 32'd3, n);
    chk("mult_lat", n, 32'd5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);

    run_op(DIV, 32'hFFFF_FFF9, 32'd2, n);
    chk("div_lat", n, 32'd10);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    run_op(DIVU, 32'd7, 32'd0, n);
    chk("divu0_lo", lo, 32'hFFFF_FFFF);
    chk("divu0_hi", hi, 32'd7);

    run_op(DIV, 32'hFFFF_FFFB, 32'd0, n);
    chk("div0_lo", lo, 32'hFFFF_FFFF);
    chk("div0_hi", hi, 32'hFFFF_FFFB);

    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
    chk("divovf_lo", lo, 32'h8000_0000);
    chk("divovf_hi", hi, 32'h0);

    // MTHI issued while a MULTU is in flight must be dropped.
    @(negedge clk);
    start = 1'b1; op = MULTU; a = 32'hFFFF_FFFF; b = 32'd2;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; op = MTHI; a = 32'd5;
    @(negedge clk); start = 1'b0;
    wait_idle("multu_idle");
    chk("multu_hi", hi, 32'd1);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    run_op(MTLO, 32'h1234_5678, 32'd0, n);
    chk("mtlo_lat", n, 32'd0);
    chk("mtlo_lo", lo, 32'h1234_5678);

    run_op(4'd13, 32'hDEAD_BEEF, 32'd1, n);
    chk("unknown_lat", n, 32'd0);
    chk("unknown_lo", lo, 32'h1234_5678);

    // Asynchronous reset in busy cycle 4 of a DIV aborts it.
    @(negedge clk);
    start = 1'b1; op = DIV; a = 32'd100; b = 32'd3;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_hi", hi, 32'h0);
    chk("arst_lo", lo, 32'h0);
    #2 reset = 1'b1;
    repeat (15) @(negedge clk);
    chk("arst_nocommit_hi", hi, 32'h0);
    chk("arst_nocommit_lo", lo, 32'h0);

`ifdef MDU_MADD_EN
    run_op(MTLO, 32'hFFFF_FFFF, 32'd0, n);
    run_op(MADDU, 32'd1, 32'd1, n);
    chk("maddu_lat", n, 32'd5);
    chk("maddu_hi", hi, 32'd1);
    chk("maddu_lo", lo, 32'd0);
    run_op(MSUB, 32'd1, 32'd1, n);
    chk("msub_hi", hi, 32'd0);
    chk("msub_lo", lo, 32'hFFFF_FFFF);
`endif

    // Random ops, including starts while busy and unknown codes.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      op    = 4'($urandom_range(0, 15));
      a     = pick();
      b     = pick();
    end
    @(negedge clk);
    start = 1'b0;
    wait_idle("final_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
